// File: rtl/imem_port_ctrl.sv
// Instruction memory port controller: shares one single-port array between
// core fetch (read) and the program loader (write), with boot sequencing.
module imem_port_ctrl #(
    parameter int          DEPTH_WORDS = 64,
    parameter int          MAX_BURST   = 4,
    parameter bit          BOOT_SKIP   = 1'b0,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_ready,
    output logic        f_valid,
    output logic [31:0] f_rdata,
    input  logic        ld_req,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_wdata,
    output logic        ld_ack,
    input  logic        ld_done,
    output logic [31:0] mem_a,
    output logic        mem_we,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd,
    output logic        core_run,
    output logic        ld_err
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);

    typedef enum logic {BOOT, RUN} state_e;
    localparam state_e RST_STATE = BOOT_SKIP ? RUN : BOOT;

    state_e        state_q, state_d;
    logic [BW-1:0] burst_q, burst_d;
    logic          core_run_q;
    logic          f_valid_q;
    logic [31:0]   f_rdata_q;
    logic          ld_err_q;

    logic ld_gnt, f_gnt;
    logic ld_ok, f_in_range;
    logic unused_addr_lsb;

    assign unused_addr_lsb = ^f_addr[1:0];

    assign ld_ok = (ld_addr[1:0] == 2'b00)
                && ({2'b00, ld_addr[31:2]} < 32'(DEPTH_WORDS));
    assign f_in_range = {2'b00, f_addr[31:2]} < 32'(DEPTH_WORDS);

    // Loader wins unless it has already starved a waiting fetch MAX_BURST times.
    always_comb begin
        ld_gnt  = 1'b0;
        f_gnt   = 1'b0;
        state_d = state_q;
        burst_d = burst_q;
        if (!reset) begin
            if (state_q == BOOT) begin
                ld_gnt = ld_req;
                if (ld_done) state_d = RUN;
            end else if (ld_req && !(f_req && burst_q == BMAX)) begin
                ld_gnt = 1'b1;
            end else if (f_req) begin
                f_gnt = 1'b1;
            end
            if (ld_gnt && f_req)
                burst_d = (burst_q == BMAX) ? BMAX : burst_q + BW'(1);
            else if (!ld_gnt)
                burst_d = '0;
        end
    end

    always_comb begin
        mem_a  = '0;
        mem_we = 1'b0;
        mem_wd = '0;
        unique case (1'b1)
            ld_gnt: begin
                mem_a  = ld_addr;
                mem_we = ld_ok;
                mem_wd = ld_wdata;
            end
            f_gnt: begin
                mem_a = {f_addr[31:2], 2'b00};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RST_STATE;
            burst_q    <= '0;
            core_run_q <= BOOT_SKIP;
            f_valid_q  <= 1'b0;
            f_rdata_q  <= '0;
            ld_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            burst_q    <= burst_d;
            core_run_q <= (state_q == RUN);
            f_valid_q  <= f_gnt;
            if (f_gnt)
                f_rdata_q <= f_in_range ? mem_rd : NOP_INSTR;
            if (ld_gnt && !ld_ok)
                ld_err_q <= 1'b1;
        end
    end

    assign f_ready  = f_gnt;
    assign ld_ack   = ld_gnt;
    assign f_valid  = f_valid_q;
    assign f_rdata  = f_rdata_q;
    assign core_run = core_run_q;
    assign ld_err   = ld_err_q;

endmodule

// File: tb/tb_imem_port_ctrl.sv
// Randomized scoreboard bench for imem_port_ctrl with a behavioural
// arbitration/memory model and a decoupled fetch-data monitor.
module tb_imem_port_ctrl;

    localparam int          DEPTH = 64;
    localparam int          MAXB  = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        f_req = 1'b0;
    logic [31:0] f_addr = '0;
    logic        f_ready, f_valid;
    logic [31:0] f_rdata;
    logic        ld_req = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [31:0] ld_wdata = '0;
    logic        ld_ack;
    logic        ld_done = 1'b0;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic        mem_we, core_run, ld_err;

    always #5 clk = ~clk;

    imem_port_ctrl #(
        .DEPTH_WORDS(DEPTH),
        .MAX_BURST  (MAXB),
        .BOOT_SKIP  (1'b0),
        .NOP_INSTR  (NOP)
    ) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_ready(f_ready),
        .f_valid(f_valid), .f_rdata(f_rdata),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_ack(ld_ack), .ld_done(ld_done),
        .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .core_run(core_run), .ld_err(ld_err)
    );

    // The physical array the controller drives.
    logic [31:0] mem [DEPTH];
    assign mem_rd = (mem_a[31:2] < DEPTH) ? mem[mem_a[7:2]] : 32'hBAD0_BAD0;
    always @(posedge clk) if (mem_we) mem[mem_a[7:2]] <= mem_wd;

    // Reference model state.
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] expq [$];
    bit  m_run = 0, m_core = 0, m_err = 0, m_fv = 0;
    int  m_burst = 0;
    int  checks = 0, fails = 0;
    bit  chk_en = 0, log_en = 0;
    bit  got_ack = 0, got_rdy = 0;
    string glog = "";

    initial for (int i = 0; i < DEPTH; i++) begin
        mem[i] = '0;
        ref_mem[i] = '0;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (chk_en) begin
        bit eg_l, eg_f, ewe;
        logic [31:0] ea;
        eg_l = 0;
        eg_f = 0;
        if (!reset) begin
            if (ld_req && (!m_run || !f_req || m_burst < MAXB)) eg_l = 1;
            else if (m_run && f_req) eg_f = 1;
        end
        ewe = eg_l && ld_addr[1:0] == 2'b00 && ld_addr[31:2] < DEPTH;
        ea = eg_l ? ld_addr : (eg_f ? {f_addr[31:2], 2'b00} : 32'h0);
        check("f_ready", f_ready, eg_f);
        check("ld_ack", ld_ack, eg_l);
        check("mem_we", mem_we, ewe);
        check("mem_a", mem_a, ea);
        check("mem_wd", mem_wd, eg_l ? ld_wdata : 32'h0);
        check("core_run", core_run, m_core);
        check("ld_err", ld_err, m_err);
        check("f_valid", f_valid, m_fv);
        got_ack = ld_ack;
        got_rdy = f_ready;
        if (log_en) begin
            if (ld_ack && f_ready) glog = {glog, "B"};
            else if (ld_ack) glog = {glog, "L"};
            else if (f_ready) glog = {glog, "F"};
            else glog = {glog, "-"};
        end
        if (eg_f)
            expq.push_back((f_addr[31:2] < DEPTH) ? ref_mem[f_addr[7:2]] : NOP);
        if (ewe) ref_mem[ld_addr[7:2]] = ld_wdata;
        if (reset) begin
            m_core = 0; m_run = 0; m_err = 0; m_fv = 0; m_burst = 0;
        end else begin
            m_core = m_run;
            if (ld_done) m_run = 1;
            if (eg_l && !ewe) m_err = 1;
            m_fv = eg_f;
            if (eg_l && f_req) m_burst = (m_burst < MAXB) ? m_burst + 1 : MAXB;
            else if (!eg_l) m_burst = 0;
        end
    end

    always @(negedge clk) if (chk_en && f_valid) begin
        logic [31:0] e;
        if (expq.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL f_rdata: valid with nothing expected, got %h", f_rdata);
        end else begin
            e = expq.pop_front();
            check("f_rdata", f_rdata, e);
        end
    end

    task automatic ld_write(input logic [31:0] a, input logic [31:0] d);
        bit ok;
        ok = 0;
        ld_req = 1; ld_addr = a; ld_wdata = d;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (ld_ack) ok = 1;
        end
        @(posedge clk); #1;
        ld_req = 0;
        if (!ok) begin
            checks++; fails++;
            $display("FAIL ld_timeout: got no ack expected ack for %h", a);
        end
    endtask

    task automatic fetch(input logic [31:0] a, input bit keep);
        bit ok;
        ok = 0;
        f_req = 1; f_addr = a;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (f_ready) ok = 1;
        end
        @(posedge clk); #1;
        if (!keep) f_req = 0;
        if (!ok) begin
            checks++; fails++;
            $display("FAIL f_timeout: got no ready expected ready for %h", a);
        end
    endtask

    initial begin
        @(posedge clk); #1;
        chk_en = 1;
        @(posedge clk); #1;
        @(negedge clk);
        check("f_rdata_reset", f_rdata, 32'h0);
        @(posedge clk); #1;
        reset = 0; f_req = 1; f_addr = 32'h8;
        repeat (5) @(posedge clk);
        #1 f_req = 0;

        ld_write(32'h8, 32'hDEAD_BEEF);
        for (int i = 0; i < 16; i++)
            if (i != 2) ld_write(32'(i * 4), $urandom);
        ld_done = 1;
        @(posedge clk); #1 ld_done = 0;
        @(posedge clk); #1;
        @(negedge clk);
        check("core_run_boot", core_run, 32'h1);
        @(posedge clk); #1;

        fetch(32'h8, 0);
        fetch(32'h200, 0);
        fetch(32'h0, 1);
        fetch(32'h4, 1);
        fetch(32'h8, 0);
        ld_write(32'h24, 32'hCAFE_F00D);
        fetch(32'h24, 0);
        @(posedge clk); #1;

        // Contention window: both held for 10 cycles.
        log_en = 1;
        ld_req = 1; ld_addr = 32'h40; ld_wdata = $urandom;
        f_req = 1; f_addr = 32'h0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (got_ack) begin
                ld_addr = 32'($urandom_range(16, 31)) << 2;
                ld_wdata = $urandom;
            end
            if (got_rdy) f_addr = 32'($urandom_range(0, 31)) << 2;
        end
        log_en = 0; ld_req = 0; f_req = 0;
        checks++;
        if (glog != "LLLLFLLLLF") begin
            fails++;
            $display("FAIL grant_pattern: got %s expected LLLLFLLLLF", glog);
        end
        @(posedge clk); #1;

        ld_write(32'h102, 32'h1111_1111);
        ld_write(32'h100, 32'h2222_2222);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("ld_err_sticky", ld_err, 32'h1);
        @(posedge clk); #1;

        for (int c = 0; c < 400; c++) begin
            if (!ld_req || got_ack) begin
                ld_req = ($urandom_range(0, 2) == 0);
                ld_addr = ($urandom_range(0, 9) == 0) ? $urandom
                          : 32'($urandom_range(0, DEPTH - 1)) << 2;
                ld_wdata = $urandom;
            end
            if (!f_req || got_rdy) begin
                f_req = ($urandom_range(0, 1) == 0);
                f_addr = (32'($urandom_range(0, 67)) << 2)
                         | 32'($urandom_range(0, 3));
            end
            ld_done = ($urandom_range(0, 49) == 0);
            @(posedge clk); #1;
        end
        ld_req = 0; f_req = 0; ld_done = 0;
        @(posedge clk); #1;

        fetch(32'h4, 0);
        reset = 1;
        @(posedge clk); #1 reset = 0;
        f_req = 1; f_addr = 32'h4;
        repeat (5) @(posedge clk);
        #1 f_req = 0;
        @(negedge clk);
        check("core_run_after_reset", core_run, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (expq.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", expq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
